// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - tile-stepping four-direction sprite motion controller
module sprite_mover #(
    parameter int SPRITE_LEN  = 32,
    parameter int STEP_PIXELS = 32,
    parameter int STEP_DELAY  = 32,
    parameter int INIT_R      = 300,
    parameter int INIT_C      = 300,
    parameter int ROW_MIN     = 0,
    parameter int ROW_MAX     = 479,
    parameter int COL_MIN     = 0,
    parameter int COL_MAX     = 639
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] player_r,
    output logic [9:0] player_c,
    output logic [1:0] facing,
    output logic       moving,
    output logic [1:0] frame_sel,
    output logic       step_done
);

    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int CW = 16;
    localparam logic [CW-1:0] DLY_LAST = CW'(STEP_DELAY - 1);
    localparam logic [CW-1:0] PIX_LAST = CW'(STEP_PIXELS - 1);
    localparam logic [CW-1:0] PIX_HALF = CW'(STEP_PIXELS / 2);

    state_t        state;
    logic [3:0]    hist;
    logic          pend_valid;
    logic [1:0]    pend_dir;
    logic [CW-1:0] dly_cnt;
    logic [CW-1:0] pix_cnt;

    logic [3:0]    btns;
    logic [3:0]    edges;
    logic [2:0]    held_sel;
    logic [2:0]    edge_sel;
    logic [2:0]    next_sel;
    logic          pixel_step;
    logic          done;
    logic          next_legal;
    logic [9:0]    step_r;
    logic [9:0]    step_c;

    // Buttons are packed {up, down, left, right}; returns {valid, direction}.
    function automatic logic [2:0] pick_dir(input logic [3:0] b);
        if (b[3]) return {1'b1, DIR_UP};
        if (b[2]) return {1'b1, DIR_DOWN};
        if (b[1]) return {1'b1, DIR_LEFT};
        if (b[0]) return {1'b1, DIR_RIGHT};
        return 3'b000;
    endfunction

    // A move is legal when the whole sprite stays on screen at the target.
    function automatic logic is_legal(input logic [1:0] dir, input logic [9:0] r,
                                      input logic [9:0] c);
        logic signed [10:0] r_s, c_s, step, lo, hi, mn, mx;
        r_s  = $signed({1'b0, r});
        c_s  = $signed({1'b0, c});
        step = 11'(STEP_PIXELS);
        case (dir)
            DIR_UP:   begin lo = r_s - step; mn = 11'(ROW_MIN); mx = 11'(ROW_MAX); end
            DIR_DOWN: begin lo = r_s + step; mn = 11'(ROW_MIN); mx = 11'(ROW_MAX); end
            DIR_LEFT: begin lo = c_s - step; mn = 11'(COL_MIN); mx = 11'(COL_MAX); end
            default:  begin lo = c_s + step; mn = 11'(COL_MIN); mx = 11'(COL_MAX); end
        endcase
        hi = lo + 11'(SPRITE_LEN - 1);
        return (lo >= mn) && (hi <= mx);
    endfunction

    // Decode this tick: edges, pixel advance, move completion and the next move's legality
    always_comb begin
        btns       = {btn_up, btn_down, btn_left, btn_right};
        edges      = btns & ~hist;
        held_sel   = pick_dir(btns);
        edge_sel   = pick_dir(edges);
        pixel_step = (state == MOVE) && (dly_cnt == DLY_LAST);
        done       = pixel_step && (pix_cnt == PIX_LAST);
        step_r     = player_r;
        step_c     = player_c;
        if (pixel_step) begin
            case (facing)
                DIR_UP:   step_r = player_r - 10'd1;
                DIR_DOWN: step_r = player_r + 10'd1;
                DIR_LEFT: step_c = player_c - 10'd1;
                default:  step_c = player_c + 10'd1;
            endcase
        end
        // Pending is only ever valid in MOVE, so IDLE sees just the held buttons.
        next_sel   = pend_valid ? {1'b1, pend_dir} : held_sel;
        next_legal = is_legal(next_sel[1:0], step_r, step_c);
    end

    // Motion FSM with registered outputs; facing doubles as the current move direction
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            player_r   <= 10'(INIT_R);
            player_c   <= 10'(INIT_C);
            facing     <= DIR_DOWN;
            moving     <= 1'b0;
            frame_sel  <= 2'd0;
            step_done  <= 1'b0;
            hist       <= 4'b0000;
            pend_valid <= 1'b0;
            pend_dir   <= DIR_DOWN;
            dly_cnt    <= '0;
            pix_cnt    <= '0;
        end else begin
            step_done <= 1'b0;
            if (tick) begin
                hist <= btns;
                if (state == IDLE) begin
                    if (next_sel[2]) begin
                        facing <= next_sel[1:0];
                        if (next_legal) begin
                            state     <= MOVE;
                            moving    <= 1'b1;
                            frame_sel <= 2'd1;
                            dly_cnt   <= '0;
                            pix_cnt   <= '0;
                        end
                    end
                end else begin
                    if (!pixel_step) begin
                        dly_cnt <= dly_cnt + 16'd1;
                    end else begin
                        dly_cnt   <= '0;
                        player_r  <= step_r;
                        player_c  <= step_c;
                        pix_cnt   <= pix_cnt + 16'd1;
                        frame_sel <= (pix_cnt + 16'd1 < PIX_HALF) ? 2'd1 : 2'd2;
                    end
                    if (done) begin
                        step_done  <= 1'b1;
                        pend_valid <= 1'b0;
                        if (next_sel[2]) facing <= next_sel[1:0];
                        if (next_sel[2] && next_legal) begin
                            // Chain straight into the next move on the completion tick.
                            dly_cnt   <= '0;
                            pix_cnt   <= '0;
                            frame_sel <= 2'd1;
                        end else begin
                            state     <= IDLE;
                            moving    <= 1'b0;
                            frame_sel <= 2'd0;
                        end
                    end else if (!pend_valid && edge_sel[2]) begin
                        pend_valid <= 1'b1;
                        pend_dir   <= edge_sel[1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - scoreboard bench for sprite_mover against a move-level model
module tb_sprite_mover;

    localparam int SP   = 4;
    localparam int SD   = 2;
    localparam int LEN  = 32;
    localparam int IR   = 300;
    localparam int IC   = 610;
    localparam int RMIN = 0;
    localparam int RMAX = 479;
    localparam int CMIN = 0;
    localparam int CMAX = 639;

    localparam logic [3:0] B_U = 4'b1000;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [9:0] player_r, player_c;
    logic [1:0] facing, frame_sel;
    logic       moving, step_done;

    sprite_mover #(
        .SPRITE_LEN(LEN), .STEP_PIXELS(SP), .STEP_DELAY(SD),
        .INIT_R(IR), .INIT_C(IC),
        .ROW_MIN(RMIN), .ROW_MAX(RMAX), .COL_MIN(CMIN), .COL_MAX(CMAX)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .player_r(player_r), .player_c(player_c), .facing(facing),
        .moving(moving), .frame_sel(frame_sel), .step_done(step_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] r;
        logic [9:0] c;
        logic [1:0] f;
        logic       mv;
        logic [1:0] fs;
        logic       sd;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a move is a start position, a direction and elapsed ticks.
    int         m_r, m_c, m_base_r, m_base_c, m_face, m_dir, m_el;
    bit         m_move, m_done;
    int         m_pend[$];
    logic [3:0] m_prev;

    function automatic int pick(input logic [3:0] b);
        if (b[3]) return 1;
        if (b[2]) return 0;
        if (b[1]) return 2;
        if (b[0]) return 3;
        return -1;
    endfunction

    function automatic int drow(input int d);
        return (d == 0) ? 1 : ((d == 1) ? -1 : 0);
    endfunction

    function automatic int dcol(input int d);
        return (d == 3) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    function automatic bit legal(input int d, input int r, input int c);
        int t;
        if (d <= 1) begin
            t = r + drow(d) * SP;
            return (t >= RMIN) && (t + LEN - 1 <= RMAX);
        end
        t = c + dcol(d) * SP;
        return (t >= CMIN) && (t + LEN - 1 <= CMAX);
    endfunction

    task automatic try_dir(input int d);
        if (d >= 0) begin
            m_face = d;
            if (legal(d, m_r, m_c)) begin
                m_move   = 1'b1;
                m_el     = 0;
                m_dir    = d;
                m_base_r = m_r;
                m_base_c = m_c;
            end
        end
    endtask

    task automatic model_step(input logic r, input logic t, input logic [3:0] b);
        int e;
        m_done = 1'b0;
        if (r) begin
            m_r = IR; m_c = IC; m_face = 0; m_move = 1'b0; m_el = 0;
            m_dir = 0; m_base_r = IR; m_base_c = IC; m_prev = 4'b0000;
            m_pend.delete();
        end else if (t) begin
            if (!m_move) begin
                try_dir(pick(b));
            end else begin
                m_el = m_el + 1;
                m_r  = m_base_r + drow(m_dir) * (m_el / SD);
                m_c  = m_base_c + dcol(m_dir) * (m_el / SD);
                if (m_el == SP * SD) begin
                    m_done = 1'b1;
                    m_move = 1'b0;
                    if (m_pend.size() > 0) try_dir(m_pend.pop_front());
                    else try_dir(pick(b));
                end else begin
                    e = pick(b & ~m_prev);
                    if (m_pend.size() == 0 && e >= 0) m_pend.push_back(e);
                end
            end
            m_prev = b;
        end
    endtask

    task automatic apply(input logic r, input logic t, input logic [3:0] b);
        exp_t x;
        @(negedge clk);
        rst = r;
        tick = t;
        {btn_up, btn_down, btn_left, btn_right} = b;
        model_step(r, t, b);
        x.r  = 10'(m_r);
        x.c  = 10'(m_c);
        x.f  = 2'(m_face);
        x.mv = m_move;
        x.fs = !m_move ? 2'd0 : (((m_el / SD) < SP / 2) ? 2'd1 : 2'd2);
        x.sd = m_done;
        sb.push_back(x);
    endtask

    task automatic apply_n(input int n, input logic t, input logic [3:0] b);
        for (int i = 0; i < n; i++) apply(1'b0, t, b);
    endtask

    // Monitor: every clk presents a new output vector; compare it with the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_vec++;
                if (player_r !== x.r || player_c !== x.c || facing !== x.f ||
                    moving !== x.mv || frame_sel !== x.fs || step_done !== x.sd) begin
                    n_err++;
                    $display("FAIL vec %0d @%0t: got r=%0d c=%0d f=%0d mv=%0d fs=%0d sd=%0d, want r=%0d c=%0d f=%0d mv=%0d fs=%0d sd=%0d",
                             n_vec, $time, player_r, player_c, facing, moving, frame_sel, step_done,
                             x.r, x.c, x.f, x.mv, x.fs, x.sd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    // Stimulus: directed scenarios, then a randomized walk with tick gaps and rare resets
    initial begin
        logic [3:0] b;
        int         sel;

        apply(1'b1, 1'b0, 4'b0000);
        apply(1'b1, 1'b0, 4'b0000);
        apply_n(10, 1'b1, 4'b0000);

        // Right is blocked at the screen edge: turn only, then a legal left move.
        apply_n(4, 1'b1, B_R);
        apply_n(1, 1'b1, B_L);
        apply_n(10, 1'b1, 4'b0000);

        // Pending buffer: up edge at tick 3 wins, left edge at tick 5 is dropped.
        apply(1'b0, 1'b1, B_L);
        apply_n(2, 1'b1, 4'b0000);
        apply(1'b0, 1'b1, B_U);
        apply(1'b0, 1'b1, 4'b0000);
        apply(1'b0, 1'b1, B_L);
        apply_n(16, 1'b1, 4'b0000);

        // Held button chains moves; some tick gaps freeze everything except step_done.
        apply_n(20, 1'b1, B_D);
        apply_n(12, 1'b1, 4'b0000);
        apply(1'b0, 1'b1, B_U);
        for (int i = 0; i < 24; i++) apply(1'b0, 1'(i % 3 != 0), 4'b0000);

        // Reset mid-move with a pending entry latched beforehand.
        apply(1'b0, 1'b1, B_L);
        apply(1'b0, 1'b1, 4'b0000);
        apply(1'b0, 1'b1, B_U);
        apply(1'b1, 1'b0, 4'b0000);
        apply_n(12, 1'b1, 4'b0000);

        b = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                sel = int'($urandom_range(0, 5));
                if (sel < 4) b = 4'(1 << sel);
                else if (sel == 4) b = 4'b0000;
                else b = 4'($urandom_range(0, 15));
            end
            apply(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 3) != 0), b);
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised four-direction sprite motion controller for the VGA game datapath: turns debounced direction buttons into tile-sized, pixel-by-pixel moves of a sprite's top-left position. It also produces facing and walk-frame selects for the sprite ROM mux. It sits between the button debouncers and the pixel-address/colour logic. It adds left/right motion, screen-bound blocking, a one-entry pending-command buffer and back-to-back moves.

## Interface
- SPRITE_LEN, 32, on-screen sprite side length in pixels
- STEP_PIXELS, 32, pixels travelled per move (must be even, ≥2)
- STEP_DELAY, 32, ticks per pixel (≥1)
- INIT_R, 300, reset row; INIT_C, 300, reset column
- ROW_MIN, 0 / ROW_MAX, 479, inclusive vertical screen bounds
- COL_MIN, 0 / COL_MAX, 639, inclusive horizontal screen bounds
- clk  in  1  single system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- tick  in  1  enable strobe; all state except reset advances only on clk edges with tick=1
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced button levels
- player_r  out  10  sprite top-left row
- player_c  out  10  sprite top-left column
- facing  out  2  0=down, 1=up, 2=left, 3=right
- moving  out  1  1 while in MOVE
- frame_sel  out  2  0=standing, 1=walk frame A, 2=walk frame B
- step_done  out  1  one-clk pulse on the tick that completes a move

## Operation
- Reset: player_r=INIT_R, player_c=INIT_C, facing=0, moving=0, frame_sel=0, step_done=0, pending empty, button history=0, counters=0, state IDLE.
- Direction selection when several buttons are held: priority up > down > left > right.
- Bound check for direction d: compute target = position ± STEP_PIXELS in 11-bit signed arithmetic. The move is legal iff target ≥ MIN and target+SPRITE_LEN−1 ≤ MAX on the affected axis.
- IDLE, tick, any button held:
  - facing ← selected direction.
  - If the move is legal: enter MOVE with pix_cnt=0 and dly_cnt=0.
  - If the move is illegal: turn only and stay IDLE.
- MOVE, each tick:
  - If dly_cnt < STEP_DELAY−1: dly_cnt+1.
  - Otherwise: dly_cnt←0, position ±1 on the axis, pix_cnt+1.
  - When the pixel just moved is the last (pix_cnt==STEP_PIXELS−1): the move is complete.
- Pending buffer:
  - Button history is sampled on ticks.
  - During MOVE, a rising edge (history 0, now 1) of any button is latched as the pending direction, using the priority rule if edges are simultaneous.
  - The buffer holds one entry; the first entry wins and later edges are ignored until it is consumed.
  - The buffer is cleared when consumed and on rst.
- Move completion tick:
  - step_done=1 for that clk.
  - Next direction: pending if valid; else the highest-priority held button; else none.
  - If there is a next direction: facing ← it. If it is legal, re-enter MOVE on that same tick with counters 0 (no IDLE cycle). If it is illegal, go IDLE.
  - If there is no next direction: go IDLE.
- frame_sel:
  - IDLE: 0.
  - MOVE: 1 while pix_cnt < STEP_PIXELS/2, else 2.
- moving = (state==MOVE).
- All outputs are registered.

## Timing
- A move lasts exactly STEP_PIXELS×STEP_DELAY ticks from the entry tick, exclusive of that tick.
- The first pixel change occurs STEP_DELAY ticks after entry.
- Between the entry tick and the first pixel change, position is unchanged.
- Outputs update on the clk edge of the qualifying tick; with tick=0, every output holds. The exception is step_done, which returns to 0 on the next clk.
- Back-to-back moves: the completion tick of move N is the entry tick of move N+1, so position advances continuously.
- rst mid-move: state, position and buffer return to reset values on the next clk, regardless of tick.
- Button changes between ticks are invisible. Edges are only detected between consecutive tick samples.

## Test plan
Parameters for all scenarios: STEP_PIXELS=4, STEP_DELAY=2, SPRITE_LEN=32.

- **Reset state:** assert rst for 2 clks, then tick every clk with no buttons -> player_r=300, player_c=300, facing=0, moving=0, frame_sel=0, step_done=0 indefinitely.
- **Single move:** press btn_right for one tick, then release -> facing=3 and moving=1 on that tick. player_c reaches 301, 302, 303, 304 on ticks 2, 4, 6, 8 after entry. frame_sel=1 for pix_cnt 0..1, then 2. step_done pulses on tick 8, then IDLE with frame_sel=0.
- **Pending buffer:** during a right move, press btn_up at tick 3, then press btn_left at tick 5, releasing both -> the next move is up only. player_r reaches 296 after 8 more ticks; btn_left is discarded.
- **Held button:** hold btn_down for 20 ticks -> two consecutive moves with no IDLE tick; player_r reaches 308 at tick 16.
- **Bound block:** INIT_C=610, hold btn_right -> facing=3, moving stays 0, player_c stays 610. Then press btn_left -> moves to 606.
- **Reset mid-move:** assert rst at tick 3 of a move -> next clk shows reset values; a pending entry latched before the reset is not executed.
